// File: rtl/shift_cmd_sequencer.sv
// Command sequencer for the 8-bit universal shift register: one load plus
// an N-step shift/rotate per accepted command, with a done pulse and held result.
module shift_cmd_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_amt,
    input  logic             cmd_nload,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [WIDTH-1:0] reg_q,
    output logic [1:0]       sr_mode,
    output logic [WIDTH-1:0] sr_data,
    output logic             sr_left_in,
    output logic             sr_right_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] OP_SHL = 3'd1;
    localparam logic [2:0] OP_SHR = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;
    localparam logic [2:0] OP_ASR = 3'd5;

    localparam logic [1:0] M_HOLD  = 2'd0;
    localparam logic [1:0] M_RIGHT = 2'd1;
    localparam logic [1:0] M_LEFT  = 2'd2;
    localparam logic [1:0] M_LOAD  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] amt_q;
    logic [WIDTH-1:0] data_q;

    logic             accept;
    logic [CNT_W-1:0] cmd_steps;
    logic [CNT_W-1:0] lat_steps;

    // Ops 0/6/7 never shift, so their amount is forced to zero here; this
    // keeps SHIFT unreachable for them even when nload skips the load.
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op >= OP_SHL) && (op <= OP_ASR);
    endfunction

    assign accept    = cmd_valid && cmd_ready;
    assign cmd_steps = is_shift_op(cmd_op) ? cmd_amt : '0;
    assign lat_steps = is_shift_op(op_q) ? amt_q : '0;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_q   <= '0;
            amt_q  <= '0;
            data_q <= '0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q   <= cmd_op;
                        amt_q  <= cmd_amt;
                        data_q <= cmd_data;
                        cnt    <= cmd_steps;
                        if (!cmd_nload)
                            state <= S_LOAD;
                        else if (cmd_steps != '0)
                            state <= S_SHIFT;
                        else
                            state <= S_DONE;
                    end
                end
                S_LOAD: begin
                    state <= (lat_steps != '0) ? S_SHIFT : S_DONE;
                end
                S_SHIFT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt <= 1)
                        state <= S_DONE;
                end
                default: begin
                    // The last shift landed on the entering edge, so reg_q is final here.
                    result <= reg_q;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        sr_mode     = M_HOLD;
        sr_data     = '0;
        sr_left_in  = 1'b0;
        sr_right_in = 1'b0;
        case (state)
            S_LOAD: begin
                sr_mode = M_LOAD;
                sr_data = data_q;
            end
            S_SHIFT: begin
                // The register shifts its parallel input, so reg_q is fed back.
                sr_data = reg_q;
                case (op_q)
                    OP_SHL: sr_mode = M_LEFT;
                    OP_ROL: begin
                        sr_mode    = M_LEFT;
                        sr_left_in = reg_q[WIDTH-1];
                    end
                    OP_SHR: sr_mode = M_RIGHT;
                    OP_ROR: begin
                        sr_mode     = M_RIGHT;
                        sr_right_in = reg_q[0];
                    end
                    OP_ASR: begin
                        sr_mode     = M_RIGHT;
                        sr_right_in = reg_q[WIDTH-1];
                    end
                    default: sr_mode = M_HOLD;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: doc/shift_cmd_sequencer.md
Name: shift_cmd_sequencer

Overview:
Command-driven controller that sits directly upstream of the team's 8-bit universal shift register. It accepts one command per handshake, which is a load plus an N-step shift or rotate. It then drives the register's 2-bit mode, parallel data and serial fill inputs cycle by cycle, and it watches the register's output. When the operation completes it presents the final register value with a one-cycle done pulse.

Parameters:
WIDTH, 8, data width; must match the shift register width
CNT_W, 3, width of shift-amount field (max amount 2^CNT_W-1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command (high only in IDLE)
cmd_op  input  3  0 LOAD-only, 1 SHL, 2 SHR, 3 ROL, 4 ROR, 5 ASR, 6/7 treated as 0
cmd_amt  input  CNT_W  number of single-bit shift steps
cmd_nload  input  1  1 = skip load, operate on current register contents
cmd_data  input  WIDTH  value loaded before shifting
reg_q  input  WIDTH  current shift-register output
sr_mode  output  2  to register: 0 hold, 1 shift right, 2 shift left, 3 parallel load
sr_data  output  WIDTH  to register parallel input
sr_left_in  output  1  serial bit entering LSB on left shift
sr_right_in  output  1  serial bit entering MSB on right shift
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse, result valid
result  output  WIDTH  registered final value, held until the next done

Behaviour:
- States are IDLE, LOAD, SHIFT and DONE. A registered copy holds op, amt, nload and data, latched at acceptance.
- Acceptance: on an edge with cmd_valid=1 and cmd_ready=1. cmd_ready is 1 only in IDLE. The latched fields are cmd_*.
- Transitions:
  - IDLE goes to LOAD on acceptance; if nload=1 it goes to SHIFT instead (amt>0) or to DONE (amt=0).
  - LOAD goes to SHIFT if amt>0, otherwise to DONE.
  - SHIFT decrements the step counter on every edge; when the counter is 1 at an edge it goes to DONE.
  - DONE goes to IDLE unconditionally.
- sr_* outputs are combinational from state, latched command and reg_q:
  - IDLE and DONE: sr_mode=0, sr_data=0, sr_left_in=0, sr_right_in=0.
  - LOAD: sr_mode=3, sr_data=latched data, fills 0.
  - SHIFT: sr_data=reg_q. The register shifts its parallel input, so reg_q is fed back.
  - SHIFT per op:
    - SHL: mode 2, left_in=0.
    - ROL: mode 2, left_in=reg_q[WIDTH-1].
    - SHR: mode 1, right_in=0.
    - ROR: mode 1, right_in=reg_q[0].
    - ASR: mode 1, right_in=reg_q[WIDTH-1].
    - The unused fill bit is always 0.
  - SHIFT with op LOAD-only: mode 0. This state is unreachable because LOAD-only goes to DONE after the load regardless of amt, and amt is ignored for op 0/6/7.
- DONE: result<=reg_q on entering the cycle after DONE, and done=1 during DONE; result is updated at the edge leaving DONE. Implementation: result is registered from reg_q while in DONE; done is asserted combinationally in DONE.
  - Correction for cleanliness: result is a register loaded with reg_q on the edge that enters DONE's successor. Bench checks result on the cycle after done=1.
- Latency, with the accept edge as E0:
  - Load performed at E1.
  - Shifts at E2..E(1+amt).
  - done high in the cycle after E(1+amt), i.e. amt+2 cycles after acceptance.
  - result valid from the following cycle.
  - With nload=1, subtract one cycle.
- Next command: accepted no earlier than the edge after DONE. No back-to-back overlap.
- Reset (rst=0 at an edge), from any state including mid-operation:
  - state goes to IDLE, counter 0, latched command 0, result 0.
  - sr_* return to 0 combinationally, so the register holds.
  - The register's own contents are not cleared by this block.
- cmd_valid while busy: ignored (cmd_ready=0). cmd_* may change freely after acceptance.
- Amount is not reduced modulo WIDTH; a maximum amount of 7 with WIDTH=8 is legal.

Test Plan:
- Reset, then load 0xA5 with ROL amt 3 -> done 5 cycles after accept; result 0x2D.
- Load 0x90 with ASR amt 2 -> result 0xE4. Load 0x90 with SHR amt 2 -> result 0x24.
- Load 0x81 with SHL amt 1 -> result 0x02. Then nload=1 with ROR amt 1 -> result 0x01, with done 2 cycles after accept.
- LOAD-only 0x3C with amt 5 -> result 0x3C, done 2 cycles after accept, no shift-mode cycles observed on sr_mode.
- Reset mid-SHIFT of ROL amt 7 -> the next cycle has busy=0, cmd_ready=1, sr_mode=0, done never pulses, result=0.
- cmd_valid held high through a whole operation -> exactly one acceptance per IDLE visit, and cmd_ready=0 throughout busy.
